// File: rtl/counter_mod_prog.sv
// counter_mod_prog: programmable-modulus up/down counter with synchronous
// clear/load, run-time modulus update, combinational terminal count for
// cascading, a one-cycle error pulse for rejected requests and a
// saturating wrap counter.
module counter_mod_prog #(
  parameter int MAX_M   = 1000,
  parameter int M_RESET = MAX_M,
  parameter int WC      = 8,
  // Count width holds MAX_M-1, modulus width holds MAX_M.
  localparam int N      = $clog2(MAX_M),
  localparam int MW     = $clog2(MAX_M + 1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          clr,
  input  logic          enable,
  input  logic          up,
  input  logic          sload,
  input  logic [N-1:0]  d,
  input  logic          m_load,
  input  logic [MW-1:0] m_in,
  output logic [N-1:0]  Q,
  output logic [MW-1:0] m_cur,
  output logic          tc,
  output logic          err,
  output logic [WC-1:0] wrap_cnt
);

  // Saturating increment: sticks at the all-ones value instead of rolling over.
  function automatic logic [WC-1:0] sat_inc(input logic [WC-1:0] v);
    if (v == {WC{1'b1}}) begin
      return v;
    end
    return v + WC'(1);
  endfunction

  logic [MW-1:0] q_ext;
  logic [MW-1:0] d_ext;
  logic          wrap_up;
  logic          wrap_dn;
  logic          wrap_step;
  logic          d_ok;
  logic          m_ok;
  logic [N-1:0]  q_next;
  logic          wrap_evt;
  logic          err_next;

  // All comparisons are done at modulus width with Q and d zero-extended.
  assign q_ext = MW'(Q);
  assign d_ext = MW'(d);

  // Wrap conditions; the down case also catches Q left above a shrunk modulus.
  assign wrap_up   = (q_ext >= (m_cur - MW'(1)));
  assign wrap_dn   = (Q == '0) || (q_ext >= m_cur);
  assign wrap_step = enable & (up ? wrap_up : wrap_dn);
  assign tc        = wrap_step;

  assign d_ok = (d_ext < m_cur);
  assign m_ok = (m_in >= MW'(2)) && (m_in <= MW'(MAX_M));

  // Next count: clr over sload over enable over hold; always uses the old modulus.
  always_comb begin
    q_next   = Q;
    wrap_evt = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (sload) begin
      q_next = d_ok ? d : '0;
    end else if (enable) begin
      wrap_evt = wrap_step;
      if (up) begin
        q_next = wrap_up ? '0 : (Q + N'(1));
      end else begin
        q_next = wrap_dn ? N'(m_cur - MW'(1)) : (Q - N'(1));
      end
    end
  end

  // A load is only rejected if it actually reaches the load stage (clr wins).
  assign err_next = (sload & ~clr & ~d_ok) | (m_load & ~m_ok);

  // Count register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      Q <= '0;
    end else begin
      Q <= q_next;
    end
  end

  // Modulus register, updated independently of the count priority chain.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      m_cur <= MW'(M_RESET);
    end else if (m_load && m_ok) begin
      m_cur <= m_in;
    end
  end

  // Error pulse register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      err <= 1'b0;
    end else begin
      err <= err_next;
    end
  end

  // Wrap counter: cleared by clr (which also discards a coincident wrap).
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wrap_cnt <= '0;
    end else if (clr) begin
      wrap_cnt <= '0;
    end else if (wrap_evt) begin
      wrap_cnt <= sat_inc(wrap_cnt);
    end
  end

endmodule

// File: tb/tb_counter_mod_prog.sv
// Testbench for counter_mod_prog: a default-parameter instance driven by
// directed and random stimulus, plus a two-stage cascade (modulus 10,
// 2-bit wrap counters), all checked against an arithmetic reference model.
module tb_counter_mod_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;

  // Main instance (defaults: MAX_M=1000, WC=8 -> N=10, MW=10)
  logic       clr, en, up, sload, m_load;
  logic [9:0] d, m_in;
  logic [9:0] q0, mc0;
  logic       tc0, err0;
  logic [7:0] wc0;

  // Cascade instances (MAX_M=16, M_RESET=10, WC=2 -> N=4, MW=5)
  logic       c_clr, c_en;
  logic [3:0] cq0, cq1;
  logic [4:0] cm0, cm1;
  logic       ctc0, ctc1, cerr0, cerr1;
  logic [1:0] cwc0, cwc1;

  counter_mod_prog dut (
    .clk(clk), .areset(areset), .clr(clr), .enable(en), .up(up),
    .sload(sload), .d(d), .m_load(m_load), .m_in(m_in),
    .Q(q0), .m_cur(mc0), .tc(tc0), .err(err0), .wrap_cnt(wc0)
  );

  counter_mod_prog #(.MAX_M(16), .M_RESET(10), .WC(2)) stg0 (
    .clk(clk), .areset(areset), .clr(c_clr), .enable(c_en), .up(1'b1),
    .sload(1'b0), .d(4'd0), .m_load(1'b0), .m_in(5'd0),
    .Q(cq0), .m_cur(cm0), .tc(ctc0), .err(cerr0), .wrap_cnt(cwc0)
  );

  counter_mod_prog #(.MAX_M(16), .M_RESET(10), .WC(2)) stg1 (
    .clk(clk), .areset(areset), .clr(c_clr), .enable(ctc0), .up(1'b1),
    .sload(1'b0), .d(4'd0), .m_load(1'b0), .m_in(5'd0),
    .Q(cq1), .m_cur(cm1), .tc(ctc1), .err(cerr1), .wrap_cnt(cwc1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state: index 0 = main, 1 = cascade stage 0, 2 = stage 1
  int mq[3], mm[3], mwc[3], merr[3];
  int p_max[3]   = '{1000, 16, 16};
  int p_mrst[3]  = '{1000, 10, 10};
  int p_wcmax[3] = '{255, 3, 3};

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; mm[k] = p_mrst[k]; mwc[k] = 0; merr[k] = 0;
    end
  endtask

  function automatic bit model_tc(input int k, input bit e, input bit u);
    if (!e) return 1'b0;
    if (u) return (mq[k] >= mm[k] - 1);
    return (mq[k] == 0) || (mq[k] >= mm[k]);
  endfunction

  task automatic model_step(input int k, input bit c, input bit e, input bit u,
                            input bit sl, input int dv, input bit ml, input int mi);
    int nq;
    bit wrapped;
    bit bad;
    nq = mq[k]; wrapped = 1'b0; bad = 1'b0;
    if (c) begin
      nq = 0;
    end else if (sl) begin
      if (dv < mm[k]) nq = dv;
      else begin nq = 0; bad = 1'b1; end
    end else if (e) begin
      wrapped = model_tc(k, e, u);
      if (wrapped) nq = u ? 0 : mm[k] - 1;
      else         nq = u ? mq[k] + 1 : mq[k] - 1;
    end
    if (c) mwc[k] = 0;
    else if (wrapped && mwc[k] < p_wcmax[k]) mwc[k] = mwc[k] + 1;
    if (ml) begin
      if (mi >= 2 && mi <= p_max[k]) mm[k] = mi;
      else bad = 1'b1;
    end
    merr[k] = bad;
    mq[k]   = nq;
  endtask

  task automatic set_main(input bit c, input bit e, input bit u, input bit sl,
                          input int dv, input bit ml, input int mi);
    clr = c; en = e; up = u; sload = sl; d = 10'(dv); m_load = ml; m_in = 10'(mi);
  endtask

  // One clock: check tc with inputs applied, step, then check registered outputs.
  task automatic tick();
    bit t0, t1;
    #1;
    t0 = model_tc(1, c_en, 1'b1);
    t1 = model_tc(2, t0, 1'b1);
    chk("tc_main", int'(tc0), int'(model_tc(0, en, up)));
    chk("tc_stg0", int'(ctc0), int'(t0));
    chk("tc_stg1", int'(ctc1), int'(t1));
    @(posedge clk);
    #1;
    model_step(0, clr, en, up, sload, int'(d), m_load, int'(m_in));
    model_step(1, c_clr, c_en, 1'b1, 1'b0, 0, 1'b0, 0);
    model_step(2, c_clr, t0, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("q_main",   int'(q0),  mq[0]);
    chk("m_main",   int'(mc0), mm[0]);
    chk("err_main", int'(err0), merr[0]);
    chk("wc_main",  int'(wc0), mwc[0]);
    chk("q_stg0",   int'(cq0), mq[1]);
    chk("wc_stg0",  int'(cwc0), mwc[1]);
    chk("q_stg1",   int'(cq1), mq[2]);
    chk("wc_stg1",  int'(cwc1), mwc[2]);
    chk("err_stg",  int'(cerr0 | cerr1), 0);
  endtask

  int wc_before;

  initial begin
    areset = 1'b0;
    set_main(0, 0, 1, 0, 0, 0, 0);
    c_clr = 1'b0; c_en = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_q", int'(q0), 0);
    chk("rst_m", int'(mc0), 1000);
    chk("rst_err", int'(err0), 0);
    chk("rst_wc", int'(wc0), 0);
    chk("rst_m_stg", int'(cm0), 10);
    @(posedge clk); #1;
    areset = 1'b1;

    // Full default cycle: 0..999 -> 0, exactly one wrap
    set_main(0, 1, 1, 0, 0, 0, 0);
    repeat (1000) tick();
    chk("full_q", int'(q0), 0);
    chk("full_wc", int'(wc0), 1);

    // Modulus 5, count up one period
    set_main(0, 0, 1, 0, 0, 1, 5); tick();
    chk("m5", int'(mc0), 5);
    set_main(0, 1, 1, 0, 0, 0, 0);
    repeat (5) tick();
    chk("m5_period_q", int'(q0), 0);
    // Rejected moduli
    set_main(0, 0, 1, 0, 0, 1, 1); tick();
    chk("m1_err", int'(err0), 1);
    chk("m1_keep", int'(mc0), 5);
    set_main(0, 0, 1, 0, 0, 1, 1001); tick();
    chk("m1001_err", int'(err0), 1);
    chk("m1001_keep", int'(mc0), 5);

    // Idle at terminal value: no wrap
    set_main(0, 0, 1, 1, 4, 0, 0); tick();
    wc_before = mwc[0];
    set_main(0, 0, 1, 0, 0, 0, 0);
    repeat (10) tick();
    chk("idle_q", int'(q0), 4);
    chk("idle_wc", int'(wc0), wc_before);

    // Shrink modulus below Q, step up
    set_main(0, 0, 1, 0, 0, 1, 10); tick();
    set_main(0, 0, 1, 1, 8, 0, 0); tick();
    set_main(0, 0, 1, 0, 0, 1, 4); tick();
    wc_before = mwc[0];
    set_main(0, 1, 1, 0, 0, 0, 0); tick();
    chk("shrink_up_q", int'(q0), 0);
    chk("shrink_up_wc", int'(wc0), wc_before + 1);
    // Same, stepping down
    set_main(0, 0, 1, 0, 0, 1, 10); tick();
    set_main(0, 0, 1, 1, 8, 0, 0); tick();
    set_main(0, 0, 1, 0, 0, 1, 4); tick();
    wc_before = mwc[0];
    set_main(0, 1, 0, 0, 0, 0, 0); tick();
    chk("shrink_dn_q", int'(q0), 3);
    chk("shrink_dn_wc", int'(wc0), wc_before + 1);

    // Loads against modulus 5
    set_main(0, 0, 1, 0, 0, 1, 5); tick();
    set_main(0, 0, 1, 1, 7, 0, 0); tick();
    chk("sload_bad_q", int'(q0), 0);
    chk("sload_bad_err", int'(err0), 1);
    set_main(0, 0, 1, 1, 4, 0, 0); tick();
    wc_before = mwc[0];
    set_main(0, 1, 1, 1, 2, 0, 0); tick();
    chk("sload_en_q", int'(q0), 2);
    chk("sload_en_wc", int'(wc0), wc_before);

    // Cascade: 100 enabled cycles
    set_main(0, 0, 1, 0, 0, 0, 0);
    c_clr = 1'b1; tick();
    c_clr = 1'b0; c_en = 1'b1;
    repeat (100) tick();
    chk("casc_q0", int'(cq0), 0);
    chk("casc_q1", int'(cq1), 0);
    chk("casc_wc1", int'(cwc1), 1);
    chk("casc_sat", int'(cwc0), 3);
    // clr on a wrap edge
    repeat (9) tick();
    chk("casc_q9", int'(cq0), 9);
    c_clr = 1'b1; tick();
    chk("clr_wrap_wc", int'(cwc0), 0);
    chk("clr_wrap_q", int'(cq0), 0);
    c_clr = 1'b0;

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      set_main(($urandom_range(0, 31) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1023)),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 1023)));
      c_en  = 1'($urandom);
      c_clr = ($urandom_range(0, 63) == 0);
      tick();
    end

    // Asynchronous reset in mid-count
    set_main(0, 1, 1, 0, 0, 1, 50); c_clr = 1'b0; c_en = 1'b1;
    tick();
    set_main(0, 1, 1, 0, 0, 0, 0);
    repeat (7) tick();
    #3;
    areset = 1'b0;
    #1;
    chk("arst_q", int'(q0), 0);
    chk("arst_m", int'(mc0), 1000);
    chk("arst_wc", int'(wc0), 0);
    chk("arst_qstg", int'(cq0), 0);
    model_reset();
    @(posedge clk); #1;
    areset = 1'b1;
    repeat (3) tick();
    chk("after_arst_q", int'(q0), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_mod_prog.md
# counter_mod_prog

Programmable-modulus up/down counter: successor to the fixed-modulus mod-M counter, with run-time modulus, direction control, synchronous clear/load, a cascadable terminal-count output and a saturating wrap counter. It sits in the timing/divider layer and feeds prescalers, baud/tick generators and cascaded multi-digit counters.

## Interface
Parameters:
- MAX_M, default 1000: largest supported modulus; must be ≥ 2.
- M_RESET, default MAX_M: modulus after reset; 2 ≤ M_RESET ≤ MAX_M.
- WC, default 8: wrap-counter width.
- Derived: N = clogb2(MAX_M-1) is the count width; MW = clogb2(MAX_M) is the modulus width. clogb2(v) is the number of bits needed to hold v.

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear.
- enable  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- sload  in  1  synchronous load of d.
- d  in  N  load value.
- m_load  in  1  latch m_in as the new modulus.
- m_in  in  MW  requested modulus.
- Q  out  N  count, registered.
- m_cur  out  MW  active modulus, registered.
- tc  out  1  terminal count, combinational.
- err  out  1  rejected-request pulse, registered.
- wrap_cnt  out  WC  saturating wrap counter, registered.

## Operation
- Reset (areset=0, asynchronous): Q=0, m_cur=M_RESET, err=0, wrap_cnt=0.
- Q priority, each edge: clr > sload > enable > hold.
  - clr: Q←0 and wrap_cnt←0.
  - sload: if d < m_cur, Q←d; otherwise Q←0 and err pulses.
  - enable, up=1: if Q ≥ m_cur-1, Q←0 (wrap); else Q←Q+1.
  - enable, up=0: if Q==0 or Q ≥ m_cur, Q←m_cur-1 (wrap); else Q←Q-1.
  - Neither: Q holds.
- Wrap happens only when enable=1. It never happens while idle, which differs from the fixed counter.
- Wrap events come only from enable steps; sload and clr never count as wraps.
  - On each wrap, wrap_cnt increments and saturates at 2^WC-1.
  - A wrap on the same edge as clr is discarded.
- Modulus update is independent of the Q priority chain.
  - m_load with 2 ≤ m_in ≤ MAX_M: m_cur←m_in at the edge.
  - m_load with any other m_in: m_cur holds and err pulses.
- On the m_load edge, the Q update uses the old m_cur. The new modulus applies from the next edge.
- Q may be ≥ m_cur after the modulus shrinks. The next enabled step then wraps as defined above (up→0, down→m_cur-1) and counts as a wrap.
- tc = enable & (up ? (Q ≥ m_cur-1) : (Q==0 | Q ≥ m_cur)).
  - tc is high exactly in cycles whose edge will wrap, unless clr or sload override that edge.
  - Cascading: tc of stage k drives enable of stage k+1.
- err is a one-cycle pulse. It is high in the cycle after any rejected sload or m_load, and the two causes are OR'd.
- Arithmetic is unsigned. Compare at MW bits, zero-extending Q. Q never leaves 0..MAX_M-1.

## Timing
- All outputs except tc are registered with 1-cycle latency; tc is combinational from Q, m_cur, enable and up.
- Reset is asserted asynchronously and released synchronously by the external synchroniser.
- Reset mid-count clears everything immediately. The first edge after release acts on Q=0.
- Direction change takes effect on the same edge. up=0 at Q=0 wraps to m_cur-1.

## Test plan
- Reset, defaults (MAX_M=1000), enable=1, up=1 for 1000 cycles: Q runs 0…999→0; tc high only at Q=999; wrap_cnt=1.
- m_load m_in=5 then count up: Q 0,1,2,3,4,0; tc at Q=4. m_in=1 and m_in=1001 each give an err pulse, and m_cur stays 5.
- m_cur=5, Q=4, enable=0 for 10 cycles: Q holds at 4, tc=0, wrap_cnt unchanged.
- Shrink modulus:
  - m_cur=10, Q=8, then m_load m_in=4: next up step gives Q=0 and wrap_cnt+1.
  - Repeat with up=0: Q=3.
- sload d=7 with m_cur=5: Q=0 and err pulses. sload+enable together with d=2: Q=2, no wrap counted.
- Two stages, m=10 each, stage-1 enable=tc of stage 0: after 100 enabled cycles both Q=0 and stage-1 wrap_cnt=1. With WC=2, saturation holds at 3. clr on a wrap edge gives wrap_cnt=0.
